// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns EX/MEM load/store requests into a
// req/gnt/rvalid bus transaction and extends the load result.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   mem_read_in, mem_write_in : load/store request
//   mem_type_in               : funct3 access size/sign
//   addr_in, store_data_in    : byte address and store source
//   dmem_*                    : data-memory bus (req/we/addr/be/wdata, gnt/rvalid/rdata)
//   stall_out                 : hold the pipeline
//   load_data_out, load_valid : extended load result and its strobe
//   access_err                : one-cycle pulse on an illegal access
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  mem_type_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid,
  output logic        access_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic [31:0] load_q;
  logic        err_q;

  logic        access;
  logic        illegal;
  logic        start;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign access = mem_read_in | mem_write_in;
  assign off    = addr_in[1:0];

  always_comb begin
    illegal = 1'b0;
    if (mem_read_in && mem_write_in) illegal = 1'b1;
    if (mem_type_in == 3'b011 || mem_type_in == 3'b110 ||
        mem_type_in == 3'b111) illegal = 1'b1;
    // Stores have no unsigned variants.
    if (mem_write_in && mem_type_in[2]) illegal = 1'b1;
    if (mem_type_in[1:0] == 2'b01 && addr_in[0]) illegal = 1'b1;
    if (mem_type_in[1:0] == 2'b10 && off != 2'b00) illegal = 1'b1;
  end

  assign start = (state_q == IDLE) && access && !illegal;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data_in;
    unique case (1'b1)
      mem_type_in[1:0] == 2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{store_data_in[7:0]}};
      end
      mem_type_in[1:0] == 2'b01: begin
        be_d    = off[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data_in[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data_in;
      end
    endcase
  end

  assign shifted = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    unique case (type_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = REQ;
      REQ:       if (dmem_gnt) state_d = we_q ? DONE : WAIT_RESP;
      WAIT_RESP: if (dmem_rvalid) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dmem_req   = 1'b0;
    stall_out  = 1'b0;
    load_valid = 1'b0;
    unique case (state_q)
      IDLE:      stall_out = start;
      REQ: begin
        dmem_req  = 1'b1;
        stall_out = 1'b1;
      end
      WAIT_RESP: stall_out = 1'b1;
      DONE:      load_valid = !we_q;
      default:   stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      off_q   <= '0;
    end else if (start) begin
      we_q    <= mem_write_in;
      addr_q  <= {addr_in[31:2], 2'b00};
      be_q    <= be_d;
      wdata_q <= mem_write_in ? wdata_d : 32'd0;
      type_q  <= mem_type_in;
      off_q   <= off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_q <= '0;
    else if (state_q == WAIT_RESP && dmem_rvalid) load_q <= ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_q == IDLE) && access && illegal;
  end

  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign load_data_out = load_q;
  assign access_err    = err_q;

endmodule
